// File: rtl/mcu_fsm.sv
// Multi-cycle main control FSM for the MIPS32 datapath: sequences fetch/decode/execute/
// memory/writeback and emits one Moore control bundle per cycle, stalling on mem_ready.
module mcu_fsm #(
  parameter int unsigned OPCODE_LEN = 6,
  parameter int unsigned ALUOP_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_LEN-1:0] OpCode,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  PCWriteCond,
  output logic                  IorD,
  output logic                  MemRd,
  output logic                  MemWr,
  output logic                  IRWrite,
  output logic                  MemtoReg,
  output logic [1:0]            PCSrc,
  output logic [ALUOP_LEN-1:0]  ALUOp,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  RegWr,
  output logic                  RegDst,
  output logic                  illegal_op,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  localparam logic [OPCODE_LEN-1:0] OpRtype = OPCODE_LEN'(6'b000000);
  localparam logic [OPCODE_LEN-1:0] OpLw    = OPCODE_LEN'(6'b100011);
  localparam logic [OPCODE_LEN-1:0] OpSw    = OPCODE_LEN'(6'b101011);
  localparam logic [OPCODE_LEN-1:0] OpBeq   = OPCODE_LEN'(6'b000100);
  localparam logic [OPCODE_LEN-1:0] OpJ     = OPCODE_LEN'(6'b000010);
  localparam logic [OPCODE_LEN-1:0] OpAddi  = OPCODE_LEN'(6'b001000);

  localparam logic [ALUOP_LEN-1:0] AluAdd   = ALUOP_LEN'(2'b00);
  localparam logic [ALUOP_LEN-1:0] AluSub   = ALUOP_LEN'(2'b01);
  localparam logic [ALUOP_LEN-1:0] AluFunct = ALUOP_LEN'(2'b10);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    ALUOp       = AluAdd;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWr       = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      StFetch: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else begin
          state_d = StFetch;
        end
      end
      StDecode: begin
        // Branch target is precomputed here while the opcode is decoded.
        ALUSrcB = 2'b11;
        case (OpCode)
          OpRtype:   state_d = StExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:     state_d = StBranch;
          OpJ:       state_d = StJump;
          OpAddi:    state_d = StAddiEx;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (OpCode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRd   = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWr   = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? StFetch : StMemWr;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWr  = 1'b1;
        RegDst = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      StJump: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWr = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    // Reset masks the whole bundle so no write can escape during the reset cycle.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRd       = 1'b0;
      MemWr       = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      PCSrc       = 2'b00;
      ALUOp       = AluAdd;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWr       = 1'b0;
      RegDst      = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  always_comb begin
    state_o = rst ? 4'd0 : state_q;
  end

endmodule

// File: tb/tb_mcu_fsm.sv
// Bench for mcu_fsm: instruction-sequence reference model checked every cycle, directed
// literal checks per instruction class, then randomized opcodes/mem_ready/reset.
module tb_mcu_fsm;

  typedef struct packed {
    logic       pcw, pcwc, iord, memrd, memwr, irw, m2r;
    logic [1:0] pcsrc, aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       regwr, regdst, ill;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b1;
  logic [5:0] OpCode = '0;
  logic       PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg;
  logic [1:0] PCSrc, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWr, RegDst, illegal_op;
  logic [3:0] state_o;

  mcu_fsm #(.OPCODE_LEN(6), .ALUOP_LEN(2)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRd(MemRd),
    .MemWr(MemWr), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWr(RegWr),
    .RegDst(RegDst), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  // Model: position within the current instruction's state list.
  int    m_pos = 0;
  int    m_len = 2;
  int    m_seq[6];
  int    hist[$];
  int    memwr_n, regwr_n, ill_n;
  ctrl_t last_act;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // State list each instruction class walks through, fetch and decode included.
  task automatic set_seq(input logic [5:0] op);
    m_seq = '{0, 1, 0, 0, 0, 0};
    case (op)
      6'b000000: begin m_seq[2] = 6;  m_seq[3] = 7;  m_len = 4; end
      6'b100011: begin m_seq[2] = 2;  m_seq[3] = 3;  m_seq[4] = 4; m_len = 5; end
      6'b101011: begin m_seq[2] = 2;  m_seq[3] = 5;  m_len = 4; end
      6'b000100: begin m_seq[2] = 8;  m_len = 3; end
      6'b000010: begin m_seq[2] = 9;  m_len = 3; end
      6'b001000: begin m_seq[2] = 10; m_seq[3] = 11; m_len = 4; end
      default:   m_len = 2;
    endcase
  endtask

  function automatic int cur_state();
    return (m_pos < 2) ? m_pos : m_seq[m_pos];
  endfunction

  function automatic ctrl_t ctrl_for(input int st, input logic mr, input logic ill);
    ctrl_t c;
    c = '0;
    case (st)
      0: begin
        c.memrd = 1'b1; c.srcb = 2'b01;
        if (mr) begin c.irw = 1'b1; c.pcw = 1'b1; end
      end
      1:  begin c.srcb = 2'b11; c.ill = ill; end
      2:  begin c.srca = 1'b1; c.srcb = 2'b10; end
      3:  begin c.memrd = 1'b1; c.iord = 1'b1; end
      4:  begin c.regwr = 1'b1; c.m2r = 1'b1; end
      5:  begin c.memwr = 1'b1; c.iord = 1'b1; end
      6:  begin c.srca = 1'b1; c.aluop = 2'b10; end
      7:  begin c.regwr = 1'b1; c.regdst = 1'b1; end
      8:  begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
      10: begin c.srca = 1'b1; c.srcb = 2'b10; end
      11: c.regwr = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input logic r, input logic mr, input logic [5:0] op);
    ctrl_t act, exp;
    int    st;
    rst = r; mem_ready = mr; OpCode = op;
    #4;
    act = '{PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg, PCSrc, ALUOp,
            ALUSrcA, ALUSrcB, RegWr, RegDst, illegal_op};
    st  = cur_state();
    exp = r ? '0 : ctrl_for(st, mr, (st == 1) && !is_legal(op));
    chk("ctrl", 32'(act), 32'(exp));
    chk("state", 32'(state_o), r ? 32'd0 : 32'(st));
    hist.push_back(int'(state_o));
    memwr_n += int'(act.memwr);
    regwr_n += int'(act.regwr);
    ill_n   += int'(act.ill);
    last_act = act;
    @(posedge clk);
    if (r) m_pos = 0;
    else if ((st == 0 || st == 3 || st == 5) && !mr) m_pos = m_pos;
    else if (st == 0) m_pos = 1;
    else if (st == 1) begin
      set_seq(op);
      m_pos = (m_len > 2) ? 2 : 0;
    end else begin
      m_pos++;
      if (m_pos >= m_len) m_pos = 0;
    end
    #1;
  endtask

  // Runs one instruction from FETCH, holding mem_ready low for 'waits' memory-wait cycles.
  task automatic instr(input logic [5:0] op, input int waits);
    int   w;
    logic mr, done;
    w = waits; done = 1'b0;
    hist.delete(); memwr_n = 0; regwr_n = 0; ill_n = 0;
    for (int i = 0; i < 30; i++) begin
      mr = 1'b1;
      if ((cur_state() == 3 || cur_state() == 5) && w > 0) begin
        mr = 1'b0;
        w--;
      end
      step(1'b0, mr, op);
      if (m_pos == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("instr_done", 32'(done), 32'd1);
    chk("return_fetch", 32'(state_o), 32'd0);
  endtask

  task automatic chk_seq(input string name, input int n, input int e[9]);
    chk({name, "_len"}, 32'(hist.size()), 32'(n));
    for (int i = 0; i < n && i < hist.size(); i++) chk(name, 32'(hist[i]), 32'(e[i]));
  endtask

  initial begin
    int    e[9];
    ctrl_t lit;
    logic [5:0] op_r;
    logic [5:0] legal[6];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    step(1'b1, 1'b1, 6'b0);
    step(1'b1, 1'b1, 6'b0);
    chk("reset_outputs", 32'(last_act), 32'd0);

    instr(6'b000000, 0);
    e = '{0, 1, 6, 7, 0, 0, 0, 0, 0};
    chk_seq("rtype_seq", 4, e);
    chk("rtype_regwr", 32'(regwr_n), 32'd1);
    lit = '0; lit.regwr = 1'b1; lit.regdst = 1'b1;
    chk("aluwb_ctrl", 32'(last_act), 32'(lit));

    instr(6'b100011, 3);
    e = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    chk_seq("lw_seq", 8, e);
    lit = '0; lit.regwr = 1'b1; lit.m2r = 1'b1;
    chk("memwb_ctrl", 32'(last_act), 32'(lit));

    instr(6'b101011, 2);
    e = '{0, 1, 2, 5, 5, 5, 0, 0, 0};
    chk_seq("sw_seq", 6, e);
    chk("sw_memwr_cycles", 32'(memwr_n), 32'd3);
    chk("sw_no_regwr", 32'(regwr_n), 32'd0);

    instr(6'b000100, 0);
    e = '{0, 1, 8, 0, 0, 0, 0, 0, 0};
    chk_seq("beq_seq", 3, e);
    lit = '0; lit.srca = 1'b1; lit.aluop = 2'b01; lit.pcwc = 1'b1; lit.pcsrc = 2'b01;
    chk("branch_ctrl", 32'(last_act), 32'(lit));

    instr(6'b000010, 0);
    e = '{0, 1, 9, 0, 0, 0, 0, 0, 0};
    chk_seq("j_seq", 3, e);
    lit = '0; lit.pcw = 1'b1; lit.pcsrc = 2'b10;
    chk("jump_ctrl", 32'(last_act), 32'(lit));

    instr(6'b001000, 0);
    e = '{0, 1, 10, 11, 0, 0, 0, 0, 0};
    chk_seq("addi_seq", 4, e);

    instr(6'b111111, 0);
    e = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("illegal_seq", 2, e);
    chk("illegal_pulses", 32'(ill_n), 32'd1);

    // Reset during a store's memory wait.
    step(1'b0, 1'b1, 6'b101011);
    step(1'b0, 1'b1, 6'b101011);
    step(1'b0, 1'b1, 6'b101011);
    step(1'b0, 1'b0, 6'b101011);
    chk("memwr_wait_high", 32'(last_act.memwr), 32'd1);
    step(1'b1, 1'b0, 6'b101011);
    chk("memwr_reset_drop", 32'(last_act.memwr), 32'd0);
    hist.delete();
    step(1'b0, 1'b0, 6'b000000);
    chk("after_reset_fetch", 32'(hist[0]), 32'd0);

    op_r = 6'b000000;
    for (int i = 0; i < 3000; i++) begin
      if (cur_state() == 0) begin
        if ($urandom_range(0, 7) < 6) op_r = legal[$urandom_range(0, 5)];
        else op_r = 6'($urandom);
      end
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), op_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_fsm.md
Name: mcu_fsm

Overview:
- Multi-cycle main control FSM for the MIPS32 datapath. Upstream neighbour of alucu: it drives the 2-bit ALUOp that alucu decodes together with Funct.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Emits one datapath control bundle per cycle and stalls on a memory ready handshake.

Parameters:
OPCODE_LEN, 6, instruction opcode width (matches `OPCODE_LEN)
ALUOP_LEN, 2, ALUOp width (matches `ALUOP_LEN)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
OpCode  in  OPCODE_LEN  opcode field IR[31:26], sampled in DECODE
mem_ready  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU Zero (beq)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRd  out  1  memory read request
MemWr  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  register write data select: 1=MDR, 0=ALUOut
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUOp  out  ALUOP_LEN  00=add, 01=sub, 10=use Funct (to alucu)
ALUSrcA  out  1  0=PC, 1=rs register
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWr  out  1  register file write enable
RegDst  out  1  destination select: 1=rd, 0=rt
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_o  out  4  current state encoding (debug/verification)

Behaviour:
- Moore FSM. All outputs are combinational decode of the state register plus mem_ready where noted. While rst=1, every output is 0 and the next state is FETCH.
- State encoding (state_o): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1. That cycle advances to DECODE; otherwise hold in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by OpCode: 000000 -> EXEC; 100011 (lw) -> MEMADR; 101011 (sw) -> MEMADR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDIEX.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no architectural write.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if OpCode=100011, else MEMWR. OpCode is held stable by the IR.
- MEMRD: MemRd=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegWr=1, RegDst=0, MemtoReg=1. Next is FETCH.
- MEMWR: MemWr=1, IorD=1. Hold until mem_ready=1, then go to FETCH. MemWr stays high for the whole wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB: RegWr=1, RegDst=1, MemtoReg=0. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01. Next is FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB: RegWr=1, RegDst=0, MemtoReg=0. Next is FETCH.
- Cycle counts with mem_ready tied 1:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
- Each cycle mem_ready is low in a wait state adds exactly one cycle.
- mem_ready is ignored in states that issue no memory request.
- Reset mid-operation (any state, including a memory wait):
  - Next cycle is FETCH with all outputs 0 during the reset cycle.
  - No RegWr, MemWr or PCWrite is asserted while rst=1.
- RegWr, MemWr and PCWrite/IRWrite are never asserted in the same cycle.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 -> during reset state_o=0 and all outputs 0. First post-reset cycle shows MemRd=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type (OpCode=000000), mem_ready=1 -> state_o sequence 0,1,6,7,0. ALUOp=10 in EXEC. RegWr=1 and RegDst=1 only in ALUWB.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0. RegWr=1 and MemtoReg=1 in state 4 only.
- sw (101011) with mem_ready low 2 cycles in MEMWR -> MemWr=1 for 3 consecutive cycles, IorD=1, RegWr never asserted, return to state 0.
- beq (000100) then j (000010) -> BRANCH shows ALUOp=01, PCWriteCond=1, PCSrc=01. JUMP shows PCWrite=1, PCSrc=10. Each instruction takes 3 cycles.
- OpCode=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state 0. Separately, assert rst during MEMWR wait -> MemWr drops to 0 that cycle, then state_o=0.
